// File: rtl/img_row_loader_if.sv
// Pixel-stream input and row-write output bundle of the image row loader.
interface img_row_loader_if #(
    parameter int IMG_W = 640,
    parameter int PIX_W = 8
);
    logic                     in_valid;
    logic [15:0]              in_data;
    logic                     img_we;
    logic [8:0]               img_addr;
    logic [IMG_W*PIX_W-1:0]   img_din;

    modport master (
        output in_valid, in_data,
        input  img_we, img_addr, img_din
    );

    modport slave (
        input  in_valid, in_data,
        output img_we, img_addr, img_din
    );
endinterface

// File: rtl/img_row_loader.sv
// Packs the 16-bit pixel stream into rows and writes them to the image SRAM.
// Optional frame checksum accumulator: IMG_ROW_LOADER_CHECKSUM_EN.
module img_row_loader #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int PIX_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    img_row_loader_if.slave   bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [26:0]       checksum
);
    localparam int RW = IMG_W * PIX_W;
    localparam int AW = $clog2(RW);
    localparam logic [8:0] WC_LAST = 9'(IMG_W / 2 - 1);
    localparam logic [8:0] RC_LAST = 9'(IMG_H - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [8:0]      r_wc;
    logic [8:0]      r_rc;
    logic [RW-1:0]   r_pack;
    logic [RW-1:0]   w_pack;
    logic [RW-1:0]   r_din;
    logic [8:0]      r_addr;
    logic            r_we;
    logic            r_err;
    logic [AW-1:0]   w_off;
    logic            w_open;
    logic            w_acc;
    logic            w_drop;
    logic            w_row_end;
    logic            w_last;

    assign w_open    = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign w_acc     = bus.in_valid && w_open;
    assign w_drop    = bus.in_valid && !w_open;
    assign w_row_end = w_acc && (r_wc == WC_LAST);
    assign w_last    = w_row_end && (r_rc == RC_LAST);
    assign w_off     = AW'({r_wc, 4'b0000});

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_LOAD: begin
                if (w_last)     w_next = S_FLUSH;
                else if (w_acc) w_next = S_LOAD;
            end
            S_FLUSH: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (r_state)
            S_IDLE: ;
            S_LOAD, S_FLUSH: busy = 1'b1;
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
        endcase
    end

    // Even column sits in the low byte of its 16-bit slot.
    always_comb begin
        w_pack = r_pack;
        w_pack[w_off +: 16] = {bus.in_data[7:0], bus.in_data[15:8]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wc   <= '0;
            r_rc   <= '0;
            r_pack <= '0;
            r_din  <= '0;
            r_addr <= '0;
            r_we   <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_we <= w_row_end;
            if (w_acc) begin
                r_pack <= w_pack;
                r_wc   <= w_row_end ? 9'd0 : r_wc + 9'd1;
            end
            if (w_row_end) begin
                r_din  <= w_pack;
                r_addr <= r_rc;
                r_rc   <= w_last ? 9'd0 : r_rc + 9'd1;
            end
            if (w_acc && r_state == S_IDLE) r_err <= 1'b0;
            else if (w_drop)                r_err <= 1'b1;
        end
    end

`ifdef IMG_ROW_LOADER_CHECKSUM_EN
    logic [26:0] r_sum;
    logic [26:0] w_add;

    assign w_add = 27'(bus.in_data[15:8]) + 27'(bus.in_data[7:0]);

    always_ff @(posedge clk) begin
        if (!rst_n)     r_sum <= '0;
        else if (w_acc) r_sum <= (r_state == S_IDLE) ? w_add : r_sum + w_add;
    end

    assign checksum = r_sum;
`else
    assign checksum = '0;
`endif

    assign bus.img_we   = r_we;
    assign bus.img_addr = r_addr;
    assign bus.img_din  = r_din;
    assign err          = r_err;
endmodule

// File: tb/tb_img_row_loader.sv
// Scoreboard bench for img_row_loader on a reduced 32x8 frame.
module tb_img_row_loader;
    localparam int W   = 32;
    localparam int H   = 8;
    localparam int DW  = W * 8;
    localparam int WPR = W / 2;
    localparam int NW  = WPR * H;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [26:0] checksum;

    img_row_loader_if #(.IMG_W(W), .PIX_W(8)) bus ();

    img_row_loader #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .checksum (checksum)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [8:0]    addr;
        logic [DW-1:0] data;
        int            at;
    } wr_t;

    typedef struct {
        int          at;
        logic [26:0] sum;
        logic        err;
    } dn_t;

    wr_t wq[$];
    dn_t dq[$];
    int  cur_kind = 0;
    int  total = 0;
    int  bad = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'((r + c) % 256);
            1:       return 8'hFF;
            default: return 8'((r * 7 + c * 3 + 64) % 256);
        endcase
    endfunction

    always @(negedge clk) begin
        wr_t e;
        dn_t d;
        if (rst_n) begin
            if (bus.img_we) begin
                if (wq.size() == 0) begin
                    chk("we_unexp", DW'(bus.img_addr), DW'(9'h1FF));
                end else begin
                    e = wq.pop_front();
                    chk("addr", DW'(bus.img_addr), DW'(e.addr));
                    chk("din", bus.img_din, e.data);
                    chk("we_cyc", DW'(cyc), DW'(e.at));
                    if (e.addr == 9'd5 && cur_kind == 0) begin
                        chk("row5_lo", DW'(bus.img_din[7:0]), DW'(5));
                        chk("row5_hi", DW'(bus.img_din[DW-1 -: 8]), DW'((5 + W - 1) % 256));
                    end
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("done_unexp", DW'(done), DW'(0));
                end else begin
                    d = dq.pop_front();
                    chk("done_cyc", DW'(cyc), DW'(d.at));
                    chk("busy_done", DW'(busy), DW'(1));
                    chk("err_done", DW'(err), DW'(d.err));
`ifdef IMG_ROW_LOADER_CHECKSUM_EN
                    chk("csum", DW'(checksum), DW'(d.sum));
`else
                    chk("csum0", DW'(checksum), DW'(0));
`endif
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic send_frame(input int kind, input bit gaps, input int nw,
                              input bit ce, input bit errx);
        logic [DW-1:0] row = '0;
        int   sum = 0;
        int   n = 0;
        bit   g;
        bit   ck = ce;
        logic [7:0] a;
        logic [7:0] b;
        cur_kind = kind;
        for (int r = 0; r < H && n < nw; r++) begin
            for (int k = 0; k < WPR && n < nw; k++) begin
                do begin
                    @(negedge clk);
                    if (ck && n == 1) begin
                        chk("err_clr", DW'(err), DW'(0));
                        ck = 1'b0;
                    end
                    g = gaps && ($urandom_range(99) < 30);
                    if (g) bus.in_valid = 1'b0;
                end while (g);
                a = pix(kind, r, 2 * k);
                b = pix(kind, r, 2 * k + 1);
                bus.in_valid = 1'b1;
                bus.in_data  = {a, b};
                row[16*k +: 8]   = a;
                row[16*k+8 +: 8] = b;
                sum += int'(a) + int'(b);
                n++;
                if (k == WPR - 1)
                    wq.push_back('{addr: 9'(r), data: row, at: cyc + 1});
                if (n == NW)
                    dq.push_back('{at: cyc + 2, sum: 27'(sum), err: errx});
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst_we", DW'(bus.img_we), DW'(0));
        chk("rst_addr", DW'(bus.img_addr), DW'(0));
        chk("rst_din", bus.img_din, DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_done", DW'(done), DW'(0));
        chk("rst_err", DW'(err), DW'(0));
        chk("rst_csum", DW'(checksum), DW'(0));
        rst_n = 1'b1;
        idle(2);

        send_frame(0, 1'b0, NW, 1'b0, 1'b0);
        idle(4);
        send_frame(0, 1'b1, NW, 1'b0, 1'b0);
        idle(4);

        send_frame(0, 1'b0, NW, 1'b0, 1'b0);
        idle(2);
        send_frame(2, 1'b0, NW, 1'b0, 1'b0);
        idle(4);

        send_frame(1, 1'b0, NW, 1'b0, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hABCD;
        @(negedge clk);
        bus.in_data  = 16'h1234;
        idle(3);
        chk("err_set", DW'(err), DW'(1));
        chk("busy_idle", DW'(busy), DW'(0));
        send_frame(0, 1'b1, NW, 1'b1, 1'b0);
        idle(4);

        send_frame(0, 1'b1, 2 * WPR + 5, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_busy", DW'(busy), DW'(0));
        chk("mid_we", DW'(bus.img_we), DW'(0));
        chk("mid_addr", DW'(bus.img_addr), DW'(0));
        rst_n = 1'b1;
        idle(2);
        send_frame(0, 1'b0, NW, 1'b0, 1'b0);
        idle(8);

        chk("wq_left", DW'(wq.size()), DW'(0));
        chk("dq_left", DW'(dq.size()), DW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/img_row_loader.md
# img_row_loader

- Input stage of the SIFT core. Receives the input image as a stream of 16-bit words on `in_valid`/`in_data`.
- Packs two 8-bit pixels per word into 640-pixel rows of 5120 bits each.
- Writes each completed row into the original-image SRAM (480 × 5120).
- Pulses `done` after the last row is written; the core FSM uses this pulse to leave IDLE and start Gaussian blurring.

## Interface
Parameters:
- `IMG_W`, 640: pixels per row.
- `IMG_H`, 480: rows per frame.
- `PIX_W`, 8: bits per pixel.

Ports:
- `clk`  input  1  clock; all logic on the rising edge.
- `rst_n`  input  1  reset, synchronous, active-low.
- `in_valid`  input  1  `in_data` is valid this cycle; gaps are allowed.
- `in_data`  input  16  `[15:8]` = pixel at even column 2k, `[7:0]` = pixel at column 2k+1.
- `img_we`  output  1  write strobe to the original-image SRAM.
- `img_addr`  output  9  row index being written (0..479).
- `img_din`  output  5120  row data; column c occupies bits `[8c+7:8c]`.
- `busy`  output  1  a frame is in progress.
- `done`  output  1  one-cycle pulse once the final row has been written.
- `err`  output  1  sticky flag: a word arrived outside LOAD.
- `checksum`  output  27  sum of all pixels in the frame (see Configuration).

## Operation
- FSM states: IDLE, LOAD, FLUSH, DONE.
- IDLE: the first `in_valid` is accepted as word 0 of row 0. State → LOAD; `err` and `checksum` clear.
- LOAD: every `in_valid` cycle accepts one word.
  - Word counter `wc` (0..319) selects the 16-bit slot `[16·wc+15:16·wc]` of the pack register. Byte order within the slot is per the `in_data` port description.
  - When `wc == 319`, the completed pack register (including the current word) is copied into the output register `img_din`, and `img_we` is registered high for one cycle with `img_addr = rc`.
  - `wc` then wraps to 0 and the row counter `rc` increments.
- The pack register and the output register are separate. The next row's word 0 may therefore arrive in the same cycle `img_we` is high, and the row being written is not corrupted.
- The final word (`rc == 479`, `wc == 319`) moves the state to FLUSH.
- FLUSH (the final-row write is in progress) → DONE. DONE asserts `done`, then → IDLE.
- `in_valid` in FLUSH or DONE: the word is dropped and `err` is set. `err` holds until the next frame starts.
- Counters are 9 bits (`wc`, `rc`). No write is issued for a partial row.
- The core holds the SRAM address/we mux on this block's outputs while `busy` is high or `img_we` is high.

## Timing
- Reset values: `img_we` = 0, `img_addr` = 0, `img_din` = 0, `busy` = 0, `done` = 0, `err` = 0, `checksum` = 0. State = IDLE, `wc` = `rc` = 0.
- Row write latency: the last word of a row is accepted at cycle T; `img_we` is high at T+1 only, with the address and data valid in that same cycle.
- Frame completion:
  - T: final word accepted.
  - T+1: `img_we` high for row 479.
  - T+2: `done` high.
  - T+3: IDLE. A new frame's first word is accepted from T+3.
- `busy` is high from the cycle after the first word is accepted through the `done` cycle inclusive.
- Minimum frame time is 153600 cycles plus 2.
- `rst_n` low mid-frame:
  - Next cycle: IDLE, counters 0, `img_we` = 0, `busy` = 0.
  - The partial row is discarded. Rows already written are left in the SRAM.

## Configuration
- Macro: `IMG_ROW_LOADER_CHECKSUM_EN`.
- Defined:
  - Each accepted word adds both of its pixels to the 27-bit `checksum` accumulator. The maximum sum, 78,336,000, cannot overflow.
  - The accumulator clears on frame start and on reset.
  - The value is final at the `done` cycle and holds until the next frame starts.
- Undefined: the `checksum` port is tied to 0 and no accumulator logic is synthesised.

## Test plan
- Ramp frame, contiguous `in_valid`, pixel(r,c) = (r+c) mod 256 → 480 writes.
  - Row 5 has `img_din[7:0]` = 5 and `img_din[5119:5112]` = (5+639) mod 256 = 132.
  - `done` arrives exactly 2 cycles after the last word.
- Same ramp with `in_valid` deasserted on random cycles (about 30 %) → identical SRAM contents. `img_we` is high exactly 1 cycle after each 320th accepted word.
- Back-to-back frames with the second frame starting at T+3 → 960 writes and 2 `done` pulses. Frame-2 row 0 holds frame-2 data. `err` = 0.
- `rst_n` low after 100 rows plus 50 words, then a full frame → no write at address 100 before the reset. The new frame writes rows 0..479 normally.
- 2 extra words sent at T+1 and T+2 → both dropped and `err` = 1. `err` clears when the next frame's first word is accepted.
- With `IMG_ROW_LOADER_CHECKSUM_EN` defined: an all-0xFF frame gives `checksum` = 78,336,000 at `done`, and a ramp frame gives the sum computed by the model. With the macro undefined, `checksum` = 0 throughout.
